cordic_prerotate: RTL and testbench

CORDIC_PREROTATE -- requirements
Module: cordic_prerotate

---
 rtl/cordic_pkg.sv | 17 +
 rtl/cordic_valid_delay.sv | 26 ++
 rtl/cordic_prerotate.sv | 101 ++++++++++
 tb/tb_cordic_prerotate.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: gain-compensated start magnitude, angle encodings,
// default chain length and the quadrant-fold predicate.
package cordic_pkg;

    localparam int                 ANGLE_W         = 16;
    localparam int                 STAGES_DEFAULT  = 16;
    localparam logic signed [15:0] K_INIT_DEFAULT  = 16'sd19897;
    localparam logic [15:0]        PI_HALF         = 16'h4000;
    localparam logic [15:0]        PI              = 16'h8000;

    // Angles in the left half-plane need a pi rotation before the chain.
    // This covers 0x4000..0xBFFF; exactly -pi/2 (0xC000) is not folded.
    function automatic logic fold_needed(input logic [ANGLE_W-1:0] angle);
        return angle[ANGLE_W-1] != angle[ANGLE_W-2];
    endfunction

endpackage

// File: rtl/cordic_valid_delay.sv
// Shift register that carries a sample-valid bit alongside the CORDIC chain.
module cordic_valid_delay #(
    parameter int DEPTH = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] v_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                v_q[i] <= v_q[i-1];
            end
        end
    end

    assign q = v_q[DEPTH-1];

endmodule

// File: rtl/cordic_prerotate.sv
// Front end of the CORDIC chain: folds the angle into the right half-plane,
// seeds x0/y0/z0, tracks result-FIFO credits and delays the valid to the chain end.
module cordic_prerotate
    import cordic_pkg::*;
#(
    parameter int                 STAGES  = STAGES_DEFAULT,
    parameter int                 CREDITS = 4,
    parameter logic signed [15:0] K_INIT  = K_INIT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [15:0]         in_angle,
    output logic signed [15:0]  x0,
    output logic signed [15:0]  y0,
    output logic [15:0]         z0,
    output logic                res_valid,
    input  logic                res_pop,
    output logic                credit_err
);

    localparam int CW = $clog2(CREDITS + 1);

    logic                accept;
    logic                fold;
    logic signed [15:0]  x0_d, x0_q;
    logic signed [15:0]  y0_d, y0_q;
    logic [15:0]         z0_d, z0_q;
    logic [CW-1:0]       credit_d, credit_q;
    logic                err_d, err_q;

    // in_ready depends only on registered credit state, never on in_valid.
    assign in_ready = (credit_q != '0);
    assign accept   = in_valid & in_ready;
    assign fold     = fold_needed(in_angle);

    // Outputs are zero on any cycle that follows a non-accepting edge.
    always_comb begin
        x0_d = '0;
        y0_d = '0;
        z0_d = '0;
        if (accept) begin
            if (fold) begin
                x0_d = -K_INIT;
                z0_d = {~in_angle[15], in_angle[14:0]};
            end else begin
                x0_d = K_INIT;
                z0_d = in_angle;
            end
        end
    end

    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        case ({accept, res_pop})
            2'b10: credit_d = credit_q - CW'(1);
            2'b01: begin
                if (credit_q == CW'(CREDITS)) begin
                    err_d = 1'b1;
                end else begin
                    credit_d = credit_q + CW'(1);
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_q     <= '0;
            y0_q     <= '0;
            z0_q     <= '0;
            credit_q <= CW'(CREDITS);
            err_q    <= 1'b0;
        end else begin
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            z0_q     <= z0_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    assign x0         = x0_q;
    assign y0         = y0_q;
    assign z0         = z0_q;
    assign credit_err = err_q;

    // One flop registers the accept, then STAGES more follow the chain.
    cordic_valid_delay #(
        .DEPTH(STAGES + 1)
    ) u_valid_delay (
        .clk(clk),
        .rst(rst),
        .d  (accept),
        .q  (res_valid)
    );

endmodule

// File: tb/tb_cordic_prerotate.sv
// Directed bench for cordic_prerotate: fold vectors, latency, credit flow, reset flush.
module tb_cordic_prerotate;

    localparam logic [15:0] KP = 16'd19897;
    localparam logic [15:0] KN = 16'hB247;   // -19897 in 16-bit two's complement

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_angle;
    logic [15:0] x0, y0, z0;
    logic        res_valid;
    logic        res_pop;
    logic        credit_err;

    int n_checks = 0;
    int n_fail   = 0;

    cordic_prerotate dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_angle  (in_angle),
        .x0        (x0),
        .y0        (y0),
        .z0        (z0),
        .res_valid (res_valid),
        .res_pop   (res_pop),
        .credit_err(credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] angle);
        @(negedge clk);
        in_valid = 1'b1;
        in_angle = angle;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk);
        res_pop = 1'b1;
        @(posedge clk);
        #1;
        res_pop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [15:0] vec_in [5] = '{16'h6000, 16'hC000, 16'h8000, 16'h4000, 16'h0000};
    logic [15:0] vec_z  [5] = '{16'hE000, 16'hC000, 16'h0000, 16'hC000, 16'h0000};
    logic [15:0] vec_x  [5] = '{KN,       KP,       KN,       KN,       KP};

    initial begin
        int lat;
        int acc;
        int pulses;
        logic rdy;
        logic [15:0] ang;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_angle = '0;
        res_pop  = 1'b0;
        idle(3);
        check_eq("rst_x0", x0, 0);
        check_eq("rst_z0", z0, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_credit_err", credit_err, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        check_eq("rst_in_ready", in_ready, 1);

        // Basic no-fold sample, one-cycle output and chain latency
        send(16'h2000);
        check_eq("a2000_x0", x0, KP);
        check_eq("a2000_y0", y0, 0);
        check_eq("a2000_z0", z0, 16'h2000);
        lat = 1;
        while (!res_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", lat, 17);
        idle(1);
        check_eq("res_valid_one_pulse", res_valid, 0);
        check_eq("idle_x0", x0, 0);
        check_eq("idle_z0", z0, 0);
        pop_one();

        // Fold and boundary vectors
        for (int i = 0; i < 5; i++) begin
            send(vec_in[i]);
            check_eq($sformatf("vec%0d_x0", i), x0, vec_x[i]);
            check_eq($sformatf("vec%0d_y0", i), y0, 0);
            check_eq($sformatf("vec%0d_z0", i), z0, vec_z[i]);
            pop_one();
        end
        idle(20);

        // Back-to-back accepts until credits run out
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ang      = 16'h0100 * 16'(i + 1);
            in_valid = 1'b1;
            in_angle = ang;
            rdy      = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                acc++;
                check_eq($sformatf("b2b%0d_z0", i), z0, ang);
            end
        end
        check_eq("b2b_accepts", acc, 4);
        check_eq("b2b_held_ready", in_ready, 0);
        check_eq("b2b_held_z0", z0, 0);
        pop_one();
        check_eq("pop_ready", in_ready, 1);
        @(posedge clk);
        #1;
        check_eq("fifth_z0", z0, 16'h0600);
        check_eq("fifth_ready", in_ready, 0);
        in_valid = 1'b0;

        // Simultaneous accept and pop at credits = 2
        pop_one();
        pop_one();
        @(negedge clk);
        in_valid = 1'b1;
        in_angle = 16'h1234;
        res_pop  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        res_pop  = 1'b0;
        check_eq("simul_ready", in_ready, 1);
        check_eq("simul_err", credit_err, 0);
        send(16'h0001);
        check_eq("simul_after1_ready", in_ready, 1);
        send(16'h0002);
        check_eq("simul_after2_ready", in_ready, 0);
        repeat (4) pop_one();
        idle(20);

        // Over-pop sets a sticky error without changing credits
        pop_one();
        check_eq("overpop_err", credit_err, 1);
        idle(5);
        check_eq("overpop_err_sticky", credit_err, 1);
        send(16'h0010);
        send(16'h0020);
        send(16'h0030);
        check_eq("overpop_3acc_ready", in_ready, 1);
        send(16'h0040);
        check_eq("overpop_4acc_ready", in_ready, 0);
        repeat (4) pop_one();
        idle(20);

        // Reset mid-flight flushes the pending valid
        send(16'h2000);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        pulses = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (res_valid) pulses++;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", in_ready, 1);
        check_eq("post_rst_x0", x0, 0);
        check_eq("post_rst_y0", y0, 0);
        check_eq("post_rst_z0", z0, 0);
        check_eq("post_rst_err", credit_err, 0);
        repeat (30) begin
            @(posedge clk);
            #1;
            if (res_valid) pulses++;
        end
        check_eq("post_rst_no_pulse", pulses, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
